alu_subtractor_serial: RTL and testbench
========================================

Name: alu_subtractor_serial

Overview:
Nibble-serial subtractor for the ALU datapath. Computes a - b - borrow_in over WIDTH/4 clock cycles, one 4-bit slice per cycle, least significant slice first. The borrow is held in a register between slices. Operands are accepted through a valid/ready handshake and the result is returned through a second valid/ready handshake. Used where the combinational carry-select adder is too large.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4. Slice count NSLICES = WIDTH/4.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start_valid  input  1  operands on a, b, borrow_in, enable are valid
start_ready  output  1  block can accept operands
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
borrow_in  input  1  incoming borrow
enable  input  1  when 0, result is forced to 0
result  output  WIDTH  difference, registered
borrow_out  output  1  final borrow, registered
done_valid  output  1  result and borrow_out are valid
done_ready  input  1  consumer accepts the result
busy  output  1  high in RUN or DONE

Behaviour:
- One clock; reset is synchronous and active-high. Reset has priority over all other inputs.
- Reset values: state=IDLE, result=0, borrow_out=0, done_valid=0, busy=0. start_ready=0 in any cycle with reset high, otherwise start_ready=(state==IDLE).
- States and transitions:
  - IDLE: start_ready=1. When start_valid is high, go to RUN and latch a, b, borrow_in and enable. Set slice index k=0 and borrow register br=borrow_in.
  - RUN: one slice per cycle. Compute {c, s} = a[4k+3:4k] + ~b[4k+3:4k] + ~br, which is 5 bits wide. Write s into result[4k+3:4k], or 0 if the latched enable is 0. Set br=~c. When k==NSLICES-1, set borrow_out=~c and go to DONE; otherwise k=k+1.
  - DONE: done_valid=1. result and borrow_out hold stable. When done_ready is high, go to IDLE and clear done_valid on the same edge.
- Latency: the accept edge is E0. done_valid is first high after edge E(NSLICES), i.e. 4 cycles for WIDTH=16.
- The earliest next accept is the cycle after the done handshake. There is no overlap between operations.
- Inputs a, b, borrow_in and enable are ignored after the accept edge. start_valid is ignored outside IDLE.
- borrow_out is computed whether or not enable is set. Only result is gated by enable.
- result slices not yet written in RUN keep their previous values. result is only meaningful while done_valid is high.
- Wrap-around: the difference is modulo 2^WIDTH. borrow_out=1 exactly when a < b + borrow_in, treating a and b as unsigned.
- If done_ready is already high when DONE is entered, done_valid is high for exactly one cycle.
- Reset mid-operation (RUN or DONE): the operation is abandoned, no done_valid pulse is produced, and outputs take their reset values.

Optional Feature:
- Macro: ALU_SUB_FLAGS_EN.
- Defined: adds two registered output ports, zero_flag (1 bit) and overflow_flag (1 bit). Both are valid with done_valid and reset to 0.
  - zero_flag: the true difference is 0. Computed even when enable=0; track by OR-reducing each slice.
  - overflow_flag: signed overflow, i.e. a[WIDTH-1] != b[WIDTH-1] and difference[WIDTH-1] != a[WIDTH-1].
- Undefined: both ports and their logic are absent. All other behaviour is identical.

Test Plan:
1. WIDTH=16, a=0x1234, b=0x0234, borrow_in=0, enable=1 -> result=0x1000, borrow_out=0, done_valid high 4 cycles after the accept edge.
2. a=0x0000, b=0x0001, borrow_in=0 -> result=0xFFFF, borrow_out=1. With flags: zero_flag=0, overflow_flag=0.
3. a=0x8000, b=0x0001 -> result=0x7FFF, borrow_out=0. With flags: overflow_flag=1. Then a=0x0005, b=0x0004, borrow_in=1 -> result=0x0000, borrow_out=0, zero_flag=1.
4. enable=0, a=0x0000, b=0x0001 -> result=0x0000, borrow_out=1.
5. Hold done_ready=0 for 3 cycles in DONE -> result, borrow_out and done_valid stay stable and start_ready stays 0. Raise done_ready -> IDLE next cycle, start_ready=1.
6. Assert reset 2 cycles into RUN -> no done_valid pulse, result=0, start_ready=1 in the first cycle after reset is released. A fresh 0x0010-0x0001 then gives 0x000F.

Source files
------------

// File: rtl/alu_subtractor_serial.sv
// alu_subtractor_serial: nibble-serial a - b - borrow_in.
// Each RUN cycle processes one 4-bit slice, least significant slice first.
// The borrow between slices is held in a register.
// Operands arrive through a start valid/ready handshake.
// The result leaves through a done valid/ready handshake.
// Optional feature macro: ALU_SUB_FLAGS_EN adds the registered zero_flag and overflow_flag outputs.
module alu_subtractor_serial #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   input  logic             enable,
   output logic [WIDTH-1:0] result,
   output logic             borrow_out,
   output logic             done_valid,
   input  logic             done_ready,
   output logic             busy
`ifdef ALU_SUB_FLAGS_EN
   ,
   output logic             zero_flag,
   output logic             overflow_flag
`endif
);

   localparam int NSLICES = WIDTH / 4;
   localparam int KW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NSLICES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             en_q, en_d;
   logic             br_q, br_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             borrow_out_q, borrow_out_d;

   logic [3:0]       a_slice;
   logic [3:0]       b_slice;
   logic [4:0]       sum5;

   // Select the current slice.
   // Subtract it as a + ~b + ~borrow, so the carry out is the inverted borrow.
   always_comb begin
      a_slice = a_q[{k_q, 2'b00} +: 4];
      b_slice = b_q[{k_q, 2'b00} +: 4];
      sum5    = {1'b0, a_slice} + {1'b0, ~b_slice} + {4'b0000, ~br_q};
   end

   // Next-state logic for the control FSM.
   // Also computes the next operand, borrow, slice index and result registers.
   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      en_d         = en_q;
      br_d         = br_q;
      k_d          = k_q;
      result_d     = result_q;
      borrow_out_d = borrow_out_q;
      case (state_q)
         IDLE: begin
            if (start_valid) begin
               state_d = RUN;
               a_d     = a;
               b_d     = b;
               en_d    = enable;
               br_d    = borrow_in;
               k_d     = '0;
            end
         end
         RUN: begin
            result_d[{k_q, 2'b00} +: 4] = en_q ? sum5[3:0] : 4'h0;
            br_d = ~sum5[4];
            if (k_q == K_LAST) begin
               borrow_out_d = ~sum5[4];
               state_d      = DONE;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         DONE: begin
            if (done_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   // Reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         a_q          <= '0;
         b_q          <= '0;
         en_q         <= 1'b0;
         br_q         <= 1'b0;
         k_q          <= '0;
         result_q     <= '0;
         borrow_out_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         en_q         <= en_d;
         br_q         <= br_d;
         k_q          <= k_d;
         result_q     <= result_d;
         borrow_out_q <= borrow_out_d;
      end
   end

`ifdef ALU_SUB_FLAGS_EN
   logic nz_q, nz_d;
   logic zero_flag_q, zero_flag_d;
   logic overflow_flag_q, overflow_flag_d;

   // Track whether any slice of the true difference was nonzero.
   // The tracking ignores enable, because the flags describe the real difference.
   always_comb begin
      nz_d            = nz_q;
      zero_flag_d     = zero_flag_q;
      overflow_flag_d = overflow_flag_q;
      if (state_q == IDLE && start_valid) begin
         nz_d = 1'b0;
      end else if (state_q == RUN) begin
         nz_d = nz_q | (|sum5[3:0]);
         if (k_q == K_LAST) begin
            zero_flag_d     = ~(nz_q | (|sum5[3:0]));
            overflow_flag_d = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (sum5[3] ^ a_q[WIDTH-1]);
         end
      end
   end

   // Flag registers, which are valid alongside done_valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         nz_q            <= 1'b0;
         zero_flag_q     <= 1'b0;
         overflow_flag_q <= 1'b0;
      end else begin
         nz_q            <= nz_d;
         zero_flag_q     <= zero_flag_d;
         overflow_flag_q <= overflow_flag_d;
      end
   end

   assign zero_flag     = zero_flag_q;
   assign overflow_flag = overflow_flag_q;
`endif

   assign start_ready = ~reset & (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign done_valid  = (state_q == DONE);
   assign result      = result_q;
   assign borrow_out  = borrow_out_q;

endmodule

// File: tb/tb_alu_subtractor_serial.sv
// Testbench for alu_subtractor_serial with WIDTH=16.
// Drives random and directed subtractions.
// Compares every output against plain-arithmetic expectations.
module tb_alu_subtractor_serial;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start_valid = 1'b0;
   logic         start_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         borrow_in = 1'b0;
   logic         enable = 1'b0;
   logic [W-1:0] result;
   logic         borrow_out;
   logic         done_valid;
   logic         done_ready = 1'b0;
   logic         busy;
`ifdef ALU_SUB_FLAGS_EN
   logic         zero_flag;
   logic         overflow_flag;
`endif

   int checks = 0;
   int failures = 0;

   alu_subtractor_serial #(.WIDTH(W)) dut (
      .clk(clk),
      .reset(reset),
      .start_valid(start_valid),
      .start_ready(start_ready),
      .a(a),
      .b(b),
      .borrow_in(borrow_in),
      .enable(enable),
      .result(result),
      .borrow_out(borrow_out),
      .done_valid(done_valid),
      .done_ready(done_ready),
      .busy(busy)
`ifdef ALU_SUB_FLAGS_EN
      ,
      .zero_flag(zero_flag),
      .overflow_flag(overflow_flag)
`endif
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   // Reference model built from unsigned arithmetic on wide integers.
   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mbin, input logic men,
                                 output logic [W-1:0] r, output logic bo,
                                 output logic zf, output logic of);
      int ai, bi, di;
      logic [W-1:0] d;
      ai = int'(ma);
      bi = int'(mb);
      di = ai - bi - int'(mbin);
      d  = W'(di);
      bo = (ai < bi + int'(mbin));
      r  = men ? d : '0;
      zf = (d == '0);
      of = (ma[W-1] != mb[W-1]) && (d[W-1] != ma[W-1]);
   endfunction

   // Present operands for one cycle and return #1 after the accept edge.
   // The inputs are then scrambled to show that the DUT latched them.
   task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tbin, input logic ten);
      @(negedge clk);
      a = ta; b = tb; borrow_in = tbin; enable = ten;
      start_valid = 1'b1;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      a = W'($urandom); b = W'($urandom);
      borrow_in = 1'($urandom); enable = 1'($urandom);
   endtask

   // Count edges after the accept edge until done_valid is seen, with a bound.
   task automatic wait_done(output int lat);
      lat = 0;
      while (!done_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   // Complete the done handshake and return #1 after that edge.
   task automatic finish_op();
      done_ready = 1'b1;
      @(posedge clk);
      #1;
      done_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (start_ready !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_start_ready: got %b expected 0", start_ready);
      end
      checks++;
      if (done_valid !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_valid_busy: got %b%b expected 00", done_valid, busy);
      end
      checks++;
      if (result !== '0 || borrow_out !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_result: got %h/%b expected 0000/0", result, borrow_out);
      end
`ifdef ALU_SUB_FLAGS_EN
      checks++;
      if (zero_flag !== 1'b0 || overflow_flag !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_flags: got %b%b expected 00", zero_flag, overflow_flag);
      end
`endif
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (start_ready !== 1'b1) begin
         failures++; $display("[TB] FAIL post_reset_ready: got %b expected 1", start_ready);
      end
   endtask

   task automatic run_and_check(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                                input logic tbin, input logic ten);
      logic [W-1:0] er;
      logic ebo, ezf, eof;
      int lat;
      model(ta, tb, tbin, ten, er, ebo, ezf, eof);
      start_op(ta, tb, tbin, ten);
      checks++;
      if (busy !== 1'b1 || start_ready !== 1'b0 || done_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL %s_run_status: got busy=%b ready=%b valid=%b expected 1 0 0",
                  name, busy, start_ready, done_valid);
      end
      wait_done(lat);
      checks++;
      if (lat !== 4) begin
         failures++; $display("[TB] FAIL %s_latency: got %0d expected 4", name, lat);
      end
      checks++;
      if (result !== er || borrow_out !== ebo) begin
         failures++;
         $display("[TB] FAIL %s_result: got %h/%b expected %h/%b", name, result, borrow_out, er, ebo);
      end
`ifdef ALU_SUB_FLAGS_EN
      checks++;
      if (zero_flag !== ezf || overflow_flag !== eof) begin
         failures++;
         $display("[TB] FAIL %s_flags: got z=%b v=%b expected z=%b v=%b",
                  name, zero_flag, overflow_flag, ezf, eof);
      end
`endif
      finish_op();
   endtask

   task automatic test_directed();
      logic [W-1:0] er;
      logic ebo, ezf, eof;
      // These are fixed constants, independent of the model.
      model(16'h1234, 16'h0234, 1'b0, 1'b1, er, ebo, ezf, eof);
      run_and_check("vec1", 16'h1234, 16'h0234, 1'b0, 1'b1);
      checks++;
      if (result !== 16'h1000 || borrow_out !== 1'b0) begin
         failures++; $display("[TB] FAIL vec1_const: got %h/%b expected 1000/0", result, borrow_out);
      end
      run_and_check("vec2", 16'h0000, 16'h0001, 1'b0, 1'b1);
      checks++;
      if (result !== 16'hFFFF || borrow_out !== 1'b1) begin
         failures++; $display("[TB] FAIL vec2_const: got %h/%b expected ffff/1", result, borrow_out);
      end
      run_and_check("vec3a", 16'h8000, 16'h0001, 1'b0, 1'b1);
      checks++;
      if (result !== 16'h7FFF || borrow_out !== 1'b0) begin
         failures++; $display("[TB] FAIL vec3a_const: got %h/%b expected 7fff/0", result, borrow_out);
      end
      run_and_check("vec3b", 16'h0005, 16'h0004, 1'b1, 1'b1);
      run_and_check("vec4_disabled", 16'h0000, 16'h0001, 1'b0, 1'b0);
      checks++;
      if (result !== 16'h0000 || borrow_out !== 1'b1) begin
         failures++; $display("[TB] FAIL vec4_const: got %h/%b expected 0000/1", result, borrow_out);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] ra, rb;
      logic rbin, ren;
      for (int i = 0; i < 30; i++) begin
         ra   = W'($urandom);
         rb   = (i % 5 == 0) ? ra : W'($urandom);
         rbin = 1'($urandom);
         ren  = ($urandom_range(0, 3) != 0);
         run_and_check("random", ra, rb, rbin, ren);
      end
   endtask

   task automatic test_hold();
      int lat;
      start_op(16'h1234, 16'h0234, 1'b0, 1'b1);
      wait_done(lat);
      // Offer a new operation while in DONE; the DUT must ignore it.
      a = 16'hFFFF; b = 16'h0001; enable = 1'b1;
      start_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (done_valid !== 1'b1 || start_ready !== 1'b0 || result !== 16'h1000 || borrow_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold_stable: got valid=%b ready=%b %h/%b expected 1 0 1000/0",
                     done_valid, start_ready, result, borrow_out);
         end
      end
      start_valid = 1'b0;
      finish_op();
      checks++;
      if (done_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL hold_release: got valid=%b ready=%b busy=%b expected 0 1 0",
                  done_valid, start_ready, busy);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      done_ready = 1'b1;
      start_op(16'h00F0, 16'h0011, 1'b0, 1'b1);
      wait_done(lat);
      checks++;
      if (result !== 16'h00DF || lat !== 4) begin
         failures++; $display("[TB] FAIL b2b_first: got %h lat=%0d expected 00df lat=4", result, lat);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done_valid !== 1'b0 || start_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL b2b_pulse: got valid=%b ready=%b expected 0 1", done_valid, start_ready);
      end
      start_op(16'h0100, 16'h0200, 1'b1, 1'b1);
      wait_done(lat);
      checks++;
      if (result !== 16'hFEFF || borrow_out !== 1'b1 || lat !== 4) begin
         failures++;
         $display("[TB] FAIL b2b_second: got %h/%b lat=%0d expected feff/1 lat=4", result, borrow_out, lat);
      end
      @(posedge clk);
      #1;
      done_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      int lat;
      int seen = 0;
      start_op(16'hABCD, 16'h1234, 1'b0, 1'b1);
      repeat (2) begin
         @(posedge clk);
         #1;
         if (done_valid) seen++;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      if (done_valid) seen++;
      checks++;
      if (seen !== 0) begin
         failures++; $display("[TB] FAIL midrun_no_done: got %0d done cycles expected 0", seen);
      end
      checks++;
      if (result !== '0 || borrow_out !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midrun_reset_state: got %h/%b busy=%b ready=%b expected 0000/0 0 0",
                  result, borrow_out, busy, start_ready);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (start_ready !== 1'b1 || result !== '0) begin
         failures++;
         $display("[TB] FAIL midrun_release: got ready=%b result=%h expected 1 0000", start_ready, result);
      end
      start_op(16'h0010, 16'h0001, 1'b0, 1'b1);
      wait_done(lat);
      checks++;
      if (result !== 16'h000F || borrow_out !== 1'b0 || lat !== 4) begin
         failures++;
         $display("[TB] FAIL midrun_fresh: got %h/%b lat=%0d expected 000f/0 lat=4", result, borrow_out, lat);
      end
      finish_op();
   endtask

   // Run every scenario in order, then report the totals.
   initial begin
      test_reset();
      test_directed();
      test_random();
      test_hold();
      test_back_to_back();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
